// File: rtl/ped_pkg.sv
// Shared types and default timing for the pedestrian crossing head.
package ped_pkg;

  typedef enum reg [1:0] {
    P_IDLE  = 2'd0,
    P_WALK  = 2'd1,
    P_FLASH = 2'd2
  } ped_state_t;

  localparam int unsigned DEF_WALK_CYCLES  = 3;
  localparam int unsigned DEF_FLASH_CYCLES = 2;
  localparam int unsigned DEF_BLINK_HALF   = 1;
  localparam int unsigned DEF_CNT_W        = 4;

  // Odd parity rules out 0 and 2 lamps lit; the AND rules out all three.
  function automatic logic is_onehot3(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for the raw push button followed by a rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/ped_crossing_signal.sv
// Pedestrian head: latches button requests and serves each one as WALK, flashing
// DON'T WALK, then steady DON'T WALK during the next vehicle red phase.
module ped_crossing_signal
  import ped_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = DEF_WALK_CYCLES,
  parameter int unsigned FLASH_CYCLES = DEF_FLASH_CYCLES,
  parameter int unsigned BLINK_HALF   = DEF_BLINK_HALF,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             ped_btn,
  output logic             walk,
  output logic             dont_walk,
  output logic             ped_wait,
  output logic [CNT_W-1:0] countdown,
  output logic             fault
);

  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CNT_W-1:0] TOTAL       = CNT_W'(WALK_CYCLES + FLASH_CYCLES);
  localparam logic [CNT_W-1:0] FLASH_TOTAL = CNT_W'(FLASH_CYCLES);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST  = BLK_W'(BLINK_HALF - 1);

  ped_state_t       state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_lvl_q, blink_lvl_d;
  logic             req_q, req_d;
  logic             red_q;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic [CNT_W-1:0] countdown_q, countdown_d;
  logic             fault_q;

  logic btn_pulse;
  logic fault_now;
  logic red_onset;
  logic abort_now;

  btn_sync_edge u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (ped_btn),
    .pulse_o(btn_pulse)
  );

  assign fault_now = ~is_onehot3(red, yellow, green);
  assign red_onset = red & ~red_q & ~fault_now;
  assign abort_now = ~red | fault_now;

  // Lamp outputs are registered from the current state, so WALK appears one
  // edge after the onset; an abort overrides them on the very next edge.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    blink_lvl_d = blink_lvl_q;
    req_d       = req_q;
    walk_d      = 1'b0;
    dont_walk_d = 1'b1;
    countdown_d = '0;

    case (state_q)
      P_IDLE: begin
        if (red_onset && req_q) begin
          state_d = P_WALK;
          phase_d = '0;
          req_d   = 1'b0;
        end
      end
      P_WALK: begin
        if (abort_now) begin
          state_d = P_IDLE;
          phase_d = '0;
        end else begin
          walk_d      = 1'b1;
          dont_walk_d = 1'b0;
          countdown_d = TOTAL - phase_q;
          if (phase_q == WALK_LAST) begin
            state_d     = P_FLASH;
            phase_d     = '0;
            blink_cnt_d = '0;
            blink_lvl_d = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      P_FLASH: begin
        if (abort_now) begin
          state_d = P_IDLE;
          phase_d = '0;
        end else begin
          dont_walk_d = blink_lvl_q;
          countdown_d = FLASH_TOTAL - phase_q;
          if (phase_q == FLASH_LAST) begin
            state_d = P_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_lvl_d = ~blink_lvl_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = P_IDLE;
        phase_d = '0;
      end
    endcase

    // A press arriving on the serving edge belongs to the next red.
    if (btn_pulse) req_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= P_IDLE;
      phase_q     <= '0;
      blink_cnt_q <= '0;
      blink_lvl_q <= 1'b1;
      req_q       <= 1'b0;
      red_q       <= 1'b1;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      countdown_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      blink_lvl_q <= blink_lvl_d;
      req_q       <= req_d;
      red_q       <= red;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      countdown_q <= countdown_d;
      fault_q     <= fault_now;
    end
  end

  assign walk      = walk_q;
  assign dont_walk = dont_walk_q;
  assign ped_wait  = req_q;
  assign countdown = countdown_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ped_crossing_signal.sv
// Randomized and directed bench for ped_crossing_signal against a cycle-count reference model.
module tb_ped_crossing_signal;

  localparam int W  = 3;
  localparam int F  = 2;
  localparam int BH = 1;

  logic       clk;
  logic       rst_n;
  logic       red, yellow, green, ped_btn;
  logic       walk, dont_walk, ped_wait, fault;
  logic [3:0] countdown;

  ped_crossing_signal dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .ped_btn  (ped_btn),
    .walk     (walk),
    .dont_walk(dont_walk),
    .ped_wait (ped_wait),
    .countdown(countdown),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: a served request is described by the edge it started on;
  // every lamp value is derived from the number of edges since then.
  int m_cyc, m_start;
  bit m_serving, m_req, m_s1, m_s2, m_prev, m_red_prev;
  bit e_walk, e_dw, e_wait, e_fault;
  int e_cd;

  task automatic model_reset();
    m_serving  = 0;
    m_req      = 0;
    m_s1       = 0;
    m_s2       = 0;
    m_prev     = 0;
    m_red_prev = 1;
    e_walk     = 0;
    e_dw       = 1;
    e_wait     = 0;
    e_fault    = 0;
    e_cd       = 0;
  endtask

  task automatic model_edge();
    int  ones, k;
    bit  fnow, onset, pulse, active;
    m_cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ones   = int'(red) + int'(yellow) + int'(green);
    fnow   = (ones != 1);
    onset  = red && !m_red_prev && !fnow;
    pulse  = m_s2 && !m_prev;
    k      = m_cyc - m_start;
    active = m_serving && (k >= 1) && (k <= W + F);
    e_walk = 0;
    e_dw   = 1;
    e_cd   = 0;
    if (active) begin
      if (!red || fnow) begin
        m_serving = 0;
      end else begin
        e_cd = W + F - k + 1;
        if (k <= W) begin
          e_walk = 1;
          e_dw   = 0;
        end else begin
          e_dw = (((k - W - 1) / BH) % 2) == 0;
        end
        if (k == W + F) m_serving = 0;
      end
    end else if (onset && m_req) begin
      m_serving = 1;
      m_start   = m_cyc;
      m_req     = 0;
    end
    if (pulse) m_req = 1;
    m_prev     = m_s2;
    m_s2       = m_s1;
    m_s1       = ped_btn;
    m_red_prev = red;
    e_fault    = fnow;
    e_wait     = m_req;
  endtask

  int walk_rises = 0;
  bit walk_prev  = 0;

  task automatic compare_all(input string ph);
    check({ph, ".walk"},      walk,      e_walk);
    check({ph, ".dont_walk"}, dont_walk, e_dw);
    check({ph, ".ped_wait"},  ped_wait,  e_wait);
    check({ph, ".countdown"}, countdown, e_cd);
    check({ph, ".fault"},     fault,     e_fault);
  endtask

  string phase = "init";

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all(phase);
    if (walk && !walk_prev) walk_rises++;
    walk_prev = walk;
  endtask

  task automatic lights(input logic r_i, input logic y_i, input logic g_i, input int n);
    red    = r_i;
    yellow = y_i;
    green  = g_i;
    repeat (n) tick();
  endtask

  task automatic press_during_green();
    red     = 1'b0;
    yellow  = 1'b0;
    green   = 1'b1;
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
  endtask

  initial begin
    m_cyc   = 0;
    m_start = 0;
    model_reset();
    rst_n   = 1'b1;
    red     = 1'b1;
    yellow  = 1'b0;
    green   = 1'b0;
    ped_btn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    phase = "reset";
    compare_all(phase);
    repeat (2) tick();
    rst_n = 1'b1;

    phase = "t1_red_no_req";
    lights(1, 0, 0, 8);

    phase = "t2_normal";
    press_during_green();
    lights(0, 0, 1, 4);
    lights(0, 1, 0, 2);
    lights(1, 0, 0, 10);
    lights(0, 0, 1, 3);

    phase = "t3_same_cycle";
    ped_btn = 1'b1;
    lights(0, 0, 1, 2);
    red = 1'b1; green = 1'b0;
    tick();
    ped_btn = 1'b0;
    lights(1, 0, 0, 8);
    lights(0, 0, 1, 3);
    lights(0, 1, 0, 1);
    lights(1, 0, 0, 10);

    phase = "t4_abort";
    press_during_green();
    lights(0, 0, 1, 3);
    lights(0, 1, 0, 1);
    lights(1, 0, 0, 3);
    lights(0, 0, 1, 5);

    phase = "t5_fault";
    press_during_green();
    lights(0, 0, 1, 3);
    lights(0, 1, 0, 2);
    lights(1, 0, 1, 3);
    lights(0, 0, 1, 2);
    lights(1, 0, 0, 10);

    phase = "t6_held_btn";
    walk_rises = 0;
    ped_btn = 1'b1;
    lights(0, 0, 1, 3);
    lights(1, 0, 0, 7);
    lights(0, 0, 1, 3);
    lights(1, 0, 0, 7);
    ped_btn = 1'b0;
    lights(0, 0, 1, 2);
    check("t6.walk_sequences", walk_rises, 1);

    phase = "t6_async_reset";
    press_during_green();
    lights(0, 0, 1, 3);
    lights(1, 0, 0, 2);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("t6_async_reset.now");
    tick();
    rst_n = 1'b1;
    lights(1, 0, 0, 4);

    phase = "random";
    for (int seg = 0; seg < 250; seg++) begin
      int sel, len;
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 10);
      if (sel <= 2)      begin red = 0; yellow = 0; green = 1; end
      else if (sel == 3) begin red = 0; yellow = 1; green = 0; end
      else if (sel <= 7) begin red = 1; yellow = 0; green = 0; end
      else if (sel == 8) begin red = 1; yellow = 0; green = 1; len = $urandom_range(1, 3); end
      else               begin red = 0; yellow = 0; green = 0; len = 1; end
      for (int c = 0; c < len; c++) begin
        ped_btn = ($urandom_range(0, 5) == 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
